// File: rtl/mem_pkg.sv
// mem_pkg: access-size encodings, adapter state encoding, captured-request
// layout and the misalignment check shared by the memory bus adapter.
// Latency: n/a (types and functions only). Backpressure: n/a.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_t;

  // Request fields held past the accept cycle. Direction is implied by the
  // state (LD_WAIT vs RMW_WR), and only the low half of store data is ever
  // merged, so neither is kept.
  typedef struct packed {
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] wdata;
  } req_cap_t;

  // Size code 3 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    return ((size == SZ_H) && off[0]) || (is_word(size) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend: picks the addressed byte/half lane of a RAM word and sign-
// or zero-extends it; words pass through. Latency: combinational.
// Backpressure: none.
// Ports: word (RAM data), offset (byte offset), size, unsigned_ld -> result.
module mem_load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (offset)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];

    result = word;
    if (!is_word(size)) begin
      if (size == SZ_H) result = {{16{lane_h[15] & ~unsigned_ld}}, lane_h};
      else              result = {{24{lane_b[7]  & ~unsigned_ld}}, lane_b};
    end
  end

endmodule

// File: rtl/mem_bus_adapter.sv
// mem_bus_adapter: load/store unit to word-wide block RAM; sub-word stores as RMW.
// Latency: word store / misaligned ack at T1, loads and sub-word stores ack at T2.
// Backpressure: ready=1 only in IDLE; a req while ready=0 is dropped, not queued.
// Ports: req/we/addr/size/unsigned_ld/wdata in, ready/ack/err/rdata out;
//        ram_wr/ram_addr/ram_din to the RAM, ram_dout from it (registered read).
module mem_bus_adapter
  import mem_pkg::*;
#(
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [1:0]      size,
  input  logic            unsigned_ld,
  input  logic [31:0]     wdata,
  output logic            ready,
  output logic            ack,
  output logic            err,
  output logic [31:0]     rdata,
  output logic            ram_wr,
  output logic [ADDR-1:0] ram_addr,
  output logic [31:0]     ram_din,
  input  logic [31:0]     ram_dout
);

  state_t          state_q, state_d;
  req_cap_t        cap_q;
  logic [ADDR-1:0] waddr_q;
  logic            accept;
  logic            mis;
  logic            capture;
  logic            ack_d, err_d;
  logic            rdata_ld, rdata_clr;
  logic [31:0]     ld_ext;
  logic [31:0]     merged;
  logic            unused_addr_hi;

  // Address bits above the RAM range wrap and are deliberately ignored.
  assign unused_addr_hi = ^addr[31:ADDR+2];

  // ready is held low during reset so nothing can be accepted.
  assign ready  = rst_n && (state_q == IDLE);
  assign accept = req && ready;
  assign mis    = misaligned(addr[1:0], size);

  mem_load_extend u_ext (
    .word        (ram_dout),
    .offset      (cap_q.off),
    .size        (cap_q.size),
    .unsigned_ld (cap_q.uns),
    .result      (ld_ext)
  );

  // Store merge: RAM read data with the addressed lane(s) overwritten.
  always_comb begin
    merged = ram_dout;
    if (cap_q.size == SZ_H) begin
      if (cap_q.off[1]) merged[31:16] = cap_q.wdata;
      else              merged[15:0]  = cap_q.wdata;
    end else begin
      case (cap_q.off)
        2'd1:    merged[15:8]  = cap_q.wdata[7:0];
        2'd2:    merged[23:16] = cap_q.wdata[7:0];
        2'd3:    merged[31:24] = cap_q.wdata[7:0];
        default: merged[7:0]   = cap_q.wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = waddr_q;
    ram_din   = merged;
    capture   = 1'b0;
    rdata_ld  = 1'b0;
    rdata_clr = 1'b0;
    case (state_q)
      IDLE: begin
        // Address and word-store data go straight through so the RAM
        // sees them in the accept cycle.
        ram_addr = addr[ADDR+1:2];
        ram_din  = wdata;
        if (accept) begin
          capture = 1'b1;
          if (mis) begin
            ack_d     = 1'b1;
            err_d     = 1'b1;
            rdata_clr = 1'b1;
          end else if (!we) begin
            state_d = LD_WAIT;
          end else if (is_word(size)) begin
            ram_wr = 1'b1;
            ack_d  = 1'b1;
          end else begin
            // The read issued now returns the word to merge into next cycle.
            state_d = RMW_WR;
          end
        end
      end
      LD_WAIT: begin
        rdata_ld = 1'b1;
        ack_d    = 1'b1;
        state_d  = IDLE;
      end
      RMW_WR: begin
        ram_wr  = 1'b1;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset abandons an RMW mid-flight without committing the write.
    ram_wr = ram_wr & rst_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      waddr_q <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      ack <= ack_d;
      err <= err_d;
      if (capture) begin
        cap_q.off   <= addr[1:0];
        cap_q.size  <= size;
        cap_q.uns   <= unsigned_ld;
        cap_q.wdata <= wdata[15:0];
        waddr_q     <= addr[ADDR+1:2];
      end
      if (rdata_ld)       rdata <= ld_ext;
      else if (rdata_clr) rdata <= '0;
    end
  end

endmodule
